// File: rtl/usb_tx_data_buffer.sv
// First-word-fall-through byte FIFO feeding the USB TX serializer.
// Pushes come from the AHB-Lite slave; pops come from the TX controller.
module usb_tx_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              store_tx_data,
    input  logic [7:0]        tx_data_in,
    input  logic              get_tx_packet_data,
    input  logic              flush_buffer,
    output logic [7:0]        tx_packet_data,
    output logic [ADDR_W:0]   tx_packet_size,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);

    // A push into a full buffer is still legal when a pop frees a slot in the same cycle.
    assign w_pop  = get_tx_packet_data && !w_empty && !flush_buffer;
    assign w_push = store_tx_data && (!w_full || w_pop) && !flush_buffer;

    // NOTE: the storage array has no reset; its contents are don't-care until written,
    // and leaving it out of the reset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_buffer) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (ADDR_W+1)'(1);
            end
            if (store_tx_data && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (get_tx_packet_data && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign tx_packet_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign tx_packet_size = r_count;
    assign buffer_full    = w_full;
    assign buffer_empty   = w_empty;
    assign overflow_err   = r_overflow;
    assign underflow_err  = r_underflow;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Scoreboard bench for usb_tx_data_buffer: pops queue their expected head byte,
// a negedge monitor compares it; status outputs are checked against hand values.
module tb_usb_tx_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic       flush_buffer = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] tx_packet_size;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q [$];

    usb_tx_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .store_tx_data      (store_tx_data),
        .tx_data_in         (tx_data_in),
        .get_tx_packet_data (get_tx_packet_data),
        .flush_buffer       (flush_buffer),
        .tx_packet_data     (tx_packet_data),
        .tx_packet_size     (tx_packet_size),
        .buffer_full        (buffer_full),
        .buffer_empty       (buffer_empty),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: the head byte in the cycle a pop strobe is held is the popped byte.
    always @(negedge clk) begin
        if (n_rst && get_tx_packet_data) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(tx_packet_data), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(tx_packet_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic s, input logic [7:0] d, input logic g,
                        input logic f, input logic [7:0] exp_pop);
        store_tx_data      = s;
        tx_data_in         = d;
        get_tx_packet_data = g;
        flush_buffer       = f;
        if (g) exp_q.push_back(exp_pop);
        @(posedge clk);
        #1;
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        flush_buffer       = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pop(input logic [7:0] exp_pop);
        step(1'b0, 8'h00, 1'b1, 1'b0, exp_pop);
    endtask

    task automatic status(input string tag, input int size, input logic full,
                          input logic empty, input logic ovf, input logic unf);
        check({tag, "_size"},  32'(tx_packet_size), 32'(size));
        check({tag, "_full"},  32'(buffer_full),    32'(full));
        check({tag, "_empty"}, 32'(buffer_empty),   32'(empty));
        check({tag, "_ovf"},   32'(overflow_err),   32'(ovf));
        check({tag, "_unf"},   32'(underflow_err),  32'(unf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset and idle
        #12;
        status("rst_hold", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        status("idle", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_data", 32'(tx_packet_data), 32'h00);

        // 2. two bytes in, two out
        push(8'hA5);
        check("t2_head_a5", 32'(tx_packet_data), 32'hA5);
        check("t2_size1", 32'(tx_packet_size), 1);
        push(8'h3C);
        check("t2_size2", 32'(tx_packet_size), 2);
        pop(8'hA5);
        check("t2_head_3c", 32'(tx_packet_data), 32'h3C);
        check("t2_size3", 32'(tx_packet_size), 1);
        pop(8'h3C);
        status("t2_end", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 3. fill, overflow, drain in order
        for (int i = 0; i < 64; i++) push(8'(i));
        status("t3_full", 64, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'hFF);
        status("t3_ovf", 64, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) pop(8'(i));
        status("t3_drained", 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        status("t3_flush", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 4. pointer wrap
        for (int i = 0; i < 40; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) pop(8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) push(8'h80 + 8'(i));
        status("t4_wrap", 40, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_head", 32'(tx_packet_data), 32'h80);

        // 5. full with push+pop, then empty with push+pop
        for (int i = 0; i < 24; i++) push(8'hC0 + 8'(i));
        status("t5_full", 64, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 8'h80);
        status("t5_full_pp", 64, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_head_adv", 32'(tx_packet_data), 32'h81);
        for (int i = 1; i < 40; i++) pop(8'h80 + 8'(i));
        for (int i = 0; i < 24; i++) pop(8'hC0 + 8'(i));
        pop(8'hEE);
        status("t5_empty", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
        status("t5_empty_pp", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_head_77", 32'(tx_packet_data), 32'h77);

        // 6. flush with both errors set and a same-cycle push
        for (int i = 0; i < 63; i++) push(8'(i));
        push(8'hFF);
        pop(8'h77);
        for (int i = 0; i < 53; i++) pop(8'(i));
        status("t6_pre", 10, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_head", 32'(tx_packet_data), 32'd53);
        step(1'b1, 8'h99, 1'b0, 1'b1, 8'h00);
        status("t6_flush", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_flush_data", 32'(tx_packet_data), 32'h00);
        push(8'h11);
        check("t6_no_99", 32'(tx_packet_data), 32'h11);
        status("t6_after", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // async reset mid-stream, away from any clock edge
        push(8'h22);
        push(8'h33);
        #2;
        n_rst = 1'b0;
        #1;
        status("t6_async", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_async_data", 32'(tx_packet_data), 32'h00);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        status("t6_released", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(8'h5A);
        pop(8'h5A);
        status("t6_final", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
